// File: rtl/broadcast_packer.sv
// broadcast_packer: captures the alpha/beta/v share vectors in one cycle and streams them as 32-bit words.
// Define BROADCAST_PACKER_BSWAP_EN to byte-swap every output word for a little-endian absorber.
module broadcast_packer #(
    parameter PARAMETER_SET = "L1",
    parameter int T = (PARAMETER_SET == "L5") ? 4 : 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [32*T-1:0] i_alpha,
    input  logic [32*T-1:0] i_beta,
    input  logic [32*T-1:0] i_v,
    output logic            o_busy,
    output logic [31:0]     o_data,
    output logic            o_data_valid,
    input  logic            i_data_ready,
    output logic            o_last,
    output logic            o_done
);

    localparam int N_WORDS = 3 * T;
    localparam int CW      = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [96*T-1:0]  r_capture;
    logic [CW-1:0]    r_count;
    logic [31:0]      w_words [N_WORDS];
    logic [31:0]      w_word;
    logic [31:0]      w_word_out;
    logic             w_last_idx;
    logic             w_xfer;

    // Capture layout {v, beta, alpha} makes word k simply bits [32k+31:32k].
    for (genvar k = 0; k < N_WORDS; k++) begin : g_words
        assign w_words[k] = r_capture[32*k +: 32];
    end

    assign w_word     = w_words[r_count];
    assign w_last_idx = (r_count == CW'(N_WORDS - 1));
    assign w_xfer     = (r_state == STREAM) && i_data_ready;

`ifdef BROADCAST_PACKER_BSWAP_EN
    assign w_word_out = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
`else
    assign w_word_out = w_word;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_capture <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && i_start) begin
                r_capture <= {i_v, i_beta, i_alpha};
                r_count   <= '0;
            end else if (w_xfer && !w_last_idx) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_data_valid = 1'b0;
        o_last       = 1'b0;
        o_done       = 1'b0;
        o_data       = 32'h0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = STREAM;
            end
            STREAM: begin
                o_busy       = 1'b1;
                o_data_valid = 1'b1;
                o_data       = w_word_out;
                o_last       = w_last_idx;
                if (w_xfer && w_last_idx) w_next_state = DONE;
            end
            DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule
